// File: rtl/game_pkg.sv
// game_pkg: shared game-state encoding, ASCII letter bounds, button indices and letter-wrap helpers
package game_pkg;
  typedef enum logic [2:0] {
    WELCOME = 3'd0,
    START   = 3'd1,
    PLAY    = 3'd2,
    PAUSE   = 3'd3,
    FINISH  = 3'd4
  } game_state_t;
  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_Z = 8'h5A;
  localparam int B_LEFT  = 0;
  localparam int B_RIGHT = 1;
  localparam int B_UP    = 2;
  localparam int B_DOWN  = 3;
  localparam int B_CHOP  = 4;
  localparam int B_CARRY = 5;
  localparam int NUM_BTN = 6;
  function automatic logic [7:0] letter_prev(input logic [7:0] c);
    return (c == ASCII_A) ? ASCII_Z : c - 8'd1;
  endfunction
  function automatic logic [7:0] letter_next(input logic [7:0] c);
    return (c == ASCII_Z) ? ASCII_A : c + 8'd1;
  endfunction
endpackage

// File: rtl/game_flow_ctrl_btn_edge.sv
// btn_edge: per-frame button history and rising-edge press vector
//  clock, reset (sync, active-low), frame_tick: history updates only on ticks
//  btn [N-1:0]: level inputs; press [N-1:0]: btn & ~history
module btn_edge #(
  parameter int N = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         frame_tick,
  input  logic [N-1:0] btn,
  output logic [N-1:0] press
);
  logic [N-1:0] prev;
  always_ff @(posedge clock) begin
    if (!reset) prev <= '0;
    else if (frame_tick) prev <= btn;
  end
  assign press = btn & ~prev;
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: Overcooked game-flow FSM (name entry, countdown, play, pause, finish)
//  clock, reset (sync, active-low), frame_tick: all activity gated by the tick
//  left/right/up/down/chop/carry: level buttons; time_up: round timer expired
//  game_state: WELCOME..FINISH; team_name: NAME_LEN ASCII letters, letter 0 in the low byte
//  name_cursor: letter being edited; start_remaining: countdown frames left
//  timer_go / restart_timer: round-timer enable and reload request
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int NAME_LEN      = 3,
  parameter int START_FRAMES  = 300,
  parameter int FINISH_FRAMES = 600
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          frame_tick,
  input  logic                          left,
  input  logic                          right,
  input  logic                          up,
  input  logic                          down,
  input  logic                          chop,
  input  logic                          carry,
  input  logic                          time_up,
  output logic [2:0]                    game_state,
  output logic [NAME_LEN-1:0][7:0]      team_name,
  output logic [$clog2(NAME_LEN):0]     name_cursor,
  output logic [15:0]                   start_remaining,
  output logic                          timer_go,
  output logic                          restart_timer
);
  localparam int CW = $clog2(NAME_LEN) + 1;
  localparam int IW = (NAME_LEN > 1) ? $clog2(NAME_LEN) : 1;
  game_state_t        state, state_next;
  logic [NUM_BTN-1:0] press;
  logic [15:0]        fin_cnt;
  logic [IW-1:0]      idx;
  logic [7:0]         cur_letter;
  logic               fin_done;
  btn_edge #(.N(NUM_BTN)) u_btn_edge (
    .clock      (clock),
    .reset      (reset),
    .frame_tick (frame_tick),
    .btn        ({carry, chop, down, up, right, left}),
    .press      (press)
  );
  assign idx        = name_cursor[IW-1:0];
  assign cur_letter = team_name[idx];
  assign fin_done   = fin_cnt == 16'(FINISH_FRAMES - 1);
  always_ff @(posedge clock) begin
    if (!reset) state <= WELCOME;
    else state <= state_next;
  end
  always_comb begin
    state_next = state;
    if (frame_tick) begin
      case (state)
        WELCOME: state_next = press[B_CHOP] ? START : WELCOME;
        START:   state_next = (start_remaining <= 16'd1) ? PLAY : START;
        PLAY:    state_next = time_up ? FINISH : (press[B_CHOP] && carry) ? PAUSE : PLAY;
        PAUSE:   state_next = (press[B_CHOP] && !carry) ? PLAY : PAUSE;
        FINISH:  state_next = (press[B_CHOP] || fin_done) ? WELCOME : FINISH;
        default: state_next = WELCOME;
      endcase
    end
  end
  // Timer handshake is a pure function of the registered state: reload is held
  // through WELCOME/START and released together with the enable on entering PLAY.
  always_comb begin
    game_state    = state;
    timer_go      = state == PLAY;
    restart_timer = state == WELCOME || state == START;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      team_name       <= {NAME_LEN{ASCII_A}};
      name_cursor     <= '0;
      start_remaining <= 16'(START_FRAMES);
      fin_cnt         <= '0;
    end else if (frame_tick) begin
      fin_cnt <= (state == FINISH && state_next == FINISH) ? fin_cnt + 16'd1 : '0;
      case (state)
        WELCOME: begin
          if (press[B_CHOP]) start_remaining <= 16'(START_FRAMES);
          else if (press[B_UP]) team_name[idx] <= letter_prev(cur_letter);
          else if (press[B_DOWN]) team_name[idx] <= letter_next(cur_letter);
          else if (press[B_RIGHT]) name_cursor <= (name_cursor == CW'(NAME_LEN - 1)) ? name_cursor : name_cursor + 1'b1;
          else if (press[B_LEFT]) name_cursor <= (name_cursor == '0) ? name_cursor : name_cursor - 1'b1;
        end
        START:   start_remaining <= (start_remaining == 16'd0) ? 16'd0 : start_remaining - 16'd1;
        FINISH:  name_cursor <= (state_next == WELCOME) ? '0 : name_cursor;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: table-driven scoreboard bench for game_flow_ctrl (NAME_LEN=3, START_FRAMES=4, FINISH_FRAMES=5)
module tb_game_flow_ctrl;
  localparam int NL = 3;
  localparam logic [5:0] L = 6'd1, R = 6'd2, U = 6'd4, D = 6'd8, C = 6'd16, K = 6'd32;
  localparam logic [23:0] AAA = 24'h414141, N1 = 24'h41415A, N2 = 24'h41425A, N3 = 24'h414241;
  logic clock = 0, reset = 0, frame_tick = 0, time_up = 0;
  logic left = 0, right = 0, up = 0, down = 0, chop = 0, carry = 0;
  logic [2:0] game_state;
  logic [NL-1:0][7:0] team_name;
  logic [1:0] name_cursor;
  logic [15:0] start_remaining;
  logic timer_go, restart_timer;
  game_flow_ctrl #(.NAME_LEN(NL), .START_FRAMES(4), .FINISH_FRAMES(5)) dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick),
    .left(left), .right(right), .up(up), .down(down), .chop(chop), .carry(carry),
    .time_up(time_up), .game_state(game_state), .team_name(team_name),
    .name_cursor(name_cursor), .start_remaining(start_remaining),
    .timer_go(timer_go), .restart_timer(restart_timer)
  );
  always #5 clock = ~clock;
  typedef struct {
    int rst;
    int idle;
    logic [5:0] b;
    logic tu;
    logic [2:0] st;
    logic [23:0] nm;
    logic [1:0] cur;
    logic [15:0] sr;
    logic tg;
    logic rt;
  } vec_t;
  vec_t vecs[$];
  vec_t sb[$];
  int applied = 0, miscompares = 0;
  function automatic vec_t mk(int rst, int idle, logic [5:0] b, logic tu, logic [2:0] st,
                              logic [23:0] nm, logic [1:0] cur, logic [15:0] sr, logic tg, logic rt);
    vec_t v;
    v.rst = rst; v.idle = idle; v.b = b; v.tu = tu; v.st = st;
    v.nm = nm; v.cur = cur; v.sr = sr; v.tg = tg; v.rt = rt;
    return v;
  endfunction
  task automatic t(input logic [5:0] b, input logic tu, input logic [2:0] st, input logic [23:0] nm,
                   input logic [1:0] cur, input logic [15:0] sr, input logic tg, input logic rt);
    vecs.push_back(mk(0, 0, b, tu, st, nm, cur, sr, tg, rt));
  endtask
  task automatic w(input logic [5:0] b, input logic [23:0] nm, input logic [1:0] cur);
    t(b, 1'b0, 3'd0, nm, cur, 16'd4, 1'b0, 1'b1);
  endtask
  task automatic check();
    vec_t e;
    e = sb.pop_front();
    applied++;
    if ({game_state, team_name, name_cursor, start_remaining, timer_go, restart_timer} !==
        {e.st, e.nm, e.cur, e.sr, e.tg, e.rt}) begin
      miscompares++;
      $display("FAIL vec%0d: got state=%0d name=%h cur=%0d rem=%0d go=%b reload=%b, want state=%0d name=%h cur=%0d rem=%0d go=%b reload=%b",
               applied - 1, game_state, team_name, name_cursor, start_remaining, timer_go, restart_timer,
               e.st, e.nm, e.cur, e.sr, e.tg, e.rt);
    end
  endtask
  initial begin
    vecs.push_back(mk(2, 0, 6'd0, 1'b0, 3'd0, AAA, 2'd0, 16'd4, 1'b0, 1'b1));
    w(U, N1, 0); w(0, N1, 0); w(R, N1, 1); w(0, N1, 1);
    w(D, N2, 1);
    repeat (9) w(D, N2, 1);
    w(0, N2, 1);
    repeat (5) begin w(R, N2, 2); w(0, N2, 2); end
    w(L, N2, 1); w(0, N2, 1); w(L, N2, 0); w(0, N2, 0); w(L, N2, 0); w(0, N2, 0);
    w(D, N3, 0); w(0, N3, 0); w(U, N2, 0); w(0, N2, 0);
    w(R, N2, 1); w(0, N2, 1); w(U | D, N1, 1); w(0, N1, 1); w(D, N2, 1); w(0, N2, 1);
    t(R | C, 0, 1, N2, 1, 4, 0, 1);
    t(0, 0, 1, N2, 1, 3, 0, 1);
    t(C, 0, 1, N2, 1, 2, 0, 1);
    t(0, 0, 1, N2, 1, 1, 0, 1);
    t(0, 0, 2, N2, 1, 0, 1, 0);
    vecs.push_back(mk(0, 5, 6'd0, 1'b0, 3'd2, N2, 2'd1, 16'd0, 1'b1, 1'b0));
    t(K, 0, 2, N2, 1, 0, 1, 0);
    t(K | C, 0, 3, N2, 1, 0, 0, 0);
    t(K, 0, 3, N2, 1, 0, 0, 0);
    t(0, 0, 3, N2, 1, 0, 0, 0);
    t(C, 0, 2, N2, 1, 0, 1, 0);
    t(0, 0, 2, N2, 1, 0, 1, 0);
    t(K | C, 0, 3, N2, 1, 0, 0, 0);
    t(K, 1, 3, N2, 1, 0, 0, 0);
    t(0, 0, 3, N2, 1, 0, 0, 0);
    t(C, 0, 2, N2, 1, 0, 1, 0);
    t(0, 0, 2, N2, 1, 0, 1, 0);
    t(K | C, 1, 4, N2, 1, 0, 0, 0);
    repeat (4) t(0, 0, 4, N2, 1, 0, 0, 0);
    t(0, 0, 0, N2, 0, 0, 0, 1);
    t(C, 0, 1, N2, 0, 4, 0, 1);
    t(0, 0, 1, N2, 0, 3, 0, 1);
    t(0, 0, 1, N2, 0, 2, 0, 1);
    t(0, 0, 1, N2, 0, 1, 0, 1);
    t(0, 0, 2, N2, 0, 0, 1, 0);
    t(0, 1, 4, N2, 0, 0, 0, 0);
    t(0, 0, 4, N2, 0, 0, 0, 0);
    t(C, 0, 0, N2, 0, 0, 0, 1);
    t(0, 0, 0, N2, 0, 0, 0, 1);
    t(C, 0, 1, N2, 0, 4, 0, 1);
    t(0, 0, 1, N2, 0, 3, 0, 1);
    vecs.push_back(mk(1, 0, C, 1'b0, 3'd0, AAA, 2'd0, 16'd4, 1'b0, 1'b1));
    t(C, 0, 1, AAA, 0, 4, 0, 1);
    t(0, 0, 1, AAA, 0, 3, 0, 1);
    @(negedge clock);
    for (int i = 0; i < vecs.size(); i++) begin
      {carry, chop, down, up, right, left} = vecs[i].b;
      time_up = vecs[i].tu;
      sb.push_back(vecs[i]);
      if (vecs[i].rst > 0) begin
        reset = 0;
        frame_tick = 1;
        repeat (vecs[i].rst) @(posedge clock);
        #1 reset = 1;
        frame_tick = 0;
      end else if (vecs[i].idle > 0) begin
        frame_tick = 0;
        repeat (vecs[i].idle) @(posedge clock);
        #1;
      end else begin
        frame_tick = 1;
        @(posedge clock);
        #1 frame_tick = 0;
      end
      check();
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
